// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Purpose  : Shared types and default sizing for the f2h_sdram port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  // Default sizing of the arbiter, usable by integrators and wrappers.
  localparam int DEF_NUM_CH          = 3;
  localparam int DEF_DATA_W          = 64;
  localparam int DEF_ADDR_W          = 29;
  localparam int DEF_BURST_W         = 8;
  localparam int DEF_MAX_OUTSTANDING = 8;

  // Command-side arbiter state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WBURST = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram_tag_fifo
// Purpose  : Synchronous FIFO holding read tags (owning channel + burst length)
//            for read commands in flight on the SDRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_tag_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin multiplexer of NUM_CH Avalon-MM bursting masters onto
//            one f2h_sdram port, with write-burst locking and in-order
//            read-response routing through a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int BURST_W         = DEF_BURST_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_CH*ADDR_W-1:0]   c_address,
  input  logic [NUM_CH*BURST_W-1:0]  c_burstcount,
  input  logic [NUM_CH-1:0]          c_read,
  input  logic [NUM_CH-1:0]          c_write,
  input  logic [NUM_CH*DATA_W-1:0]   c_writedata,
  input  logic [NUM_CH*DATA_W/8-1:0] c_byteenable,
  output logic [NUM_CH-1:0]          c_waitrequest,
  output logic [DATA_W-1:0]          c_readdata,
  output logic [NUM_CH-1:0]          c_readdatavalid,
  output logic [ADDR_W-1:0]          m_address,
  output logic [BURST_W-1:0]         m_burstcount,
  output logic                       m_read,
  output logic                       m_write,
  output logic [DATA_W-1:0]          m_writedata,
  output logic [DATA_W/8-1:0]        m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [DATA_W-1:0]          m_readdata,
  input  logic                       m_readdatavalid,
  output logic                       err_rdv
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int BE_W  = DATA_W / 8;
  localparam int TAG_W = CH_W + BURST_W;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [BURST_W-1:0] burst;
  } tag_t;

  // Per-channel views of the packed client buses.
  logic [ADDR_W-1:0]  w_addr  [NUM_CH];
  logic [BURST_W-1:0] w_bcnt  [NUM_CH];
  logic [DATA_W-1:0]  w_wdata [NUM_CH];
  logic [BE_W-1:0]    w_be    [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    // A zero burstcount is treated as a single beat everywhere downstream.
    assign w_addr[gi]  = c_address[gi*ADDR_W +: ADDR_W];
    assign w_bcnt[gi]  = (c_burstcount[gi*BURST_W +: BURST_W] == '0) ?
                         BURST_W'(1) : c_burstcount[gi*BURST_W +: BURST_W];
    assign w_wdata[gi] = c_writedata[gi*DATA_W +: DATA_W];
    assign w_be[gi]    = c_byteenable[gi*BE_W +: BE_W];
  end

  // First requester at or after ptr, wrapping from NUM_CH-1 back to 0.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx[CH_W-1:0]]) begin
        rr_pick = CH_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  arb_state_e          r_state, w_state_nxt;
  logic [CH_W-1:0]     r_grant, w_grant_nxt;
  logic [CH_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [BURST_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic [BURST_W-1:0]  r_rcnt;
  logic                r_err_rdv;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [NUM_CH-1:0]   w_req;
  logic                w_g_read;
  logic                w_g_write;
  logic [CH_W-1:0]     w_after_grant;
  logic [TAG_W-1:0]    w_push_raw;
  logic [TAG_W-1:0]    w_head_raw;
  tag_t                w_push_tag;
  tag_t                w_head;
  logic                w_rdv_ok;
  logic [BURST_W-1:0]  w_beats_left;
  logic                w_last_beat;

  // Reads are masked while every tag slot is in use; writes never need a tag.
  assign w_req         = (c_read & ~{NUM_CH{w_full}}) | c_write;
  assign w_g_read      = c_read[r_grant] & ~w_full;
  assign w_g_write     = c_write[r_grant];
  assign w_after_grant = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

  // The command side always shows the granted client; the strobes qualify it.
  assign m_address    = w_addr[r_grant];
  assign m_burstcount = w_bcnt[r_grant];
  assign m_writedata  = w_wdata[r_grant];
  assign m_byteenable = w_be[r_grant];

  // Arbiter state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  // Next-state, grant and command-strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_nxt      = r_rr_ptr;
    w_wcnt_nxt    = r_wcnt;
    w_push        = 1'b0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    c_waitrequest = '1;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_nxt = rr_pick(w_req, r_rr_ptr);
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        if (w_g_write) begin
          m_write                = 1'b1;
          c_waitrequest[r_grant] = m_waitrequest;
          if (!m_waitrequest) begin
            w_rr_nxt = w_after_grant;
            if (w_bcnt[r_grant] == BURST_W'(1)) begin
              w_state_nxt = IDLE;
            end else begin
              w_wcnt_nxt  = w_bcnt[r_grant] - 1'b1;
              w_state_nxt = WBURST;
            end
          end
        end else if (w_g_read) begin
          m_read                 = 1'b1;
          c_waitrequest[r_grant] = m_waitrequest;
          if (!m_waitrequest) begin
            w_push      = 1'b1;
            w_rr_nxt    = w_after_grant;
            w_state_nxt = IDLE;
          end
        end else begin
          // Client withdrew its request before acceptance: nothing issued.
          w_rr_nxt    = w_after_grant;
          w_state_nxt = IDLE;
        end
      end
      WBURST: begin
        m_write                = c_write[r_grant];
        c_waitrequest[r_grant] = m_waitrequest;
        if (c_write[r_grant] && !m_waitrequest) begin
          w_wcnt_nxt = r_wcnt - 1'b1;
          if (r_wcnt == BURST_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_push_tag = '{ch: r_grant, burst: w_bcnt[r_grant]};
  assign w_push_raw = w_push_tag;
  assign w_head     = tag_t'(w_head_raw);

  sdram_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_raw),
    .i_pop       (w_pop),
    .o_head      (w_head_raw),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Response routing: beats belong to the oldest outstanding tag.
  assign w_rdv_ok        = m_readdatavalid & ~w_empty;
  assign w_beats_left    = (r_rcnt == '0) ? w_head.burst : r_rcnt;
  assign w_last_beat     = (w_beats_left == BURST_W'(1));
  assign w_pop           = w_rdv_ok & w_last_beat;
  assign c_readdata      = m_readdata;
  assign c_readdatavalid = w_rdv_ok ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_head.ch) : '0;
  assign err_rdv         = r_err_rdv;

  // Beat counter for the head tag and the sticky orphan-beat flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rcnt    <= '0;
      r_err_rdv <= 1'b0;
    end else begin
      if (w_rdv_ok) r_rcnt <= w_last_beat ? '0 : w_beats_left - 1'b1;
      if (m_readdatavalid && w_empty) r_err_rdv <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Self-checking bench for sdram_port_arbiter: arbitration table,
//            directed multi-cycle corners and a randomized traffic run against
//            a transaction-level model of clients and SDRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int NCH = 3;
  localparam int DW  = 64;
  localparam int AW  = 29;
  localparam int BW  = 8;
  localparam int BEW = DW / 8;

  logic                clk = 1'b0;
  logic                reset_reset_n;
  logic [NCH*AW-1:0]   c_address;
  logic [NCH*BW-1:0]   c_burstcount;
  logic [NCH-1:0]      c_read, c_write;
  logic [NCH*DW-1:0]   c_writedata;
  logic [NCH*BEW-1:0]  c_byteenable;
  logic [NCH-1:0]      c_waitrequest, c_readdatavalid;
  logic [DW-1:0]       c_readdata;
  logic [AW-1:0]       m_address;
  logic [BW-1:0]       m_burstcount;
  logic                m_read, m_write, m_waitrequest, m_readdatavalid, err_rdv;
  logic [DW-1:0]       m_writedata, m_readdata;
  logic [BEW-1:0]      m_byteenable;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_OUTSTANDING(8)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .c_address(c_address), .c_burstcount(c_burstcount), .c_read(c_read), .c_write(c_write),
    .c_writedata(c_writedata), .c_byteenable(c_byteenable), .c_waitrequest(c_waitrequest),
    .c_readdata(c_readdata), .c_readdatavalid(c_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .err_rdv(err_rdv));

  int checks = 0;
  int errors = 0;

  // Client-side intent, packed onto the DUT buses by drive_clients.
  logic          cl_rd [NCH];
  logic          cl_wr [NCH];
  logic [AW-1:0] cl_addr [NCH];
  logic [BW-1:0] cl_bc [NCH];
  logic [DW-1:0] cl_wd [NCH];
  logic [BEW-1:0] cl_be [NCH];
  logic          cl_act [NCH];
  int            cl_left [NCH];
  int            cl_beat [NCH];

  // Read beats the modelled SDRAM still owes, in port order.
  typedef struct { logic [DW-1:0] data; int ch; } beat_t;
  beat_t beatq[$];

  typedef struct packed { logic [2:0] rd; logic [2:0] wr; logic [1:0] g; } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_clients();
    for (int i = 0; i < NCH; i++) begin
      c_read[i]                    = cl_rd[i];
      c_write[i]                   = cl_wr[i];
      c_address[i*AW +: AW]        = cl_addr[i];
      c_burstcount[i*BW +: BW]     = cl_bc[i];
      c_writedata[i*DW +: DW]      = cl_wd[i];
      c_byteenable[i*BEW +: BEW]   = cl_be[i];
    end
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cl_rd[i] = 1'b0; cl_wr[i] = 1'b0; cl_act[i] = 1'b0; cl_bc[i] = 8'd1;
      cl_addr[i] = AW'(256 * (i + 1)); cl_wd[i] = '0; cl_be[i] = '1;
      cl_left[i] = 0; cl_beat[i] = 0;
    end
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    drive_clients();
    beatq.delete();
    repeat (2) @(posedge clk);
    #1 reset_reset_n = 1'b1;
  endtask

  // Called just after inputs are driven; returns at the negedge of acceptance.
  task automatic wait_accept(input int ch, input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!c_waitrequest[ch]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  // Randomized traffic: clients hold requests until accepted, port stalls and
  // returns read beats at random; every beat is checked against the owner
  // recorded when the port accepted the command.
  task automatic run_random(input int ncyc, input bit fair);
    int  cyc = 0;
    int  last_ch = NCH - 1;
    int  grants [NCH];
    bit  stop = 1'b0;
    bit  pres;
    bit  idle;
    int  ch;
    for (int i = 0; i < NCH; i++) grants[i] = 0;
    while (1) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        if (!cl_act[i] && !stop && (fair || $urandom_range(0, 3) == 0)) begin
          cl_act[i]  = 1'b1;
          cl_wr[i]   = fair ? 1'b0 : ($urandom_range(0, 2) == 0);
          cl_rd[i]   = ~cl_wr[i];
          cl_addr[i] = AW'((i << 20) | $urandom_range(0, 16'hFFFF));
          cl_bc[i]   = fair ? 8'd1 : 8'($urandom_range(1, 4));
          cl_left[i] = int'(cl_bc[i]);
          cl_beat[i] = 0;
          cl_wd[i]   = {8'(i), 24'd0, 32'($urandom)};
          cl_be[i]   = 8'($urandom);
        end
      end
      m_waitrequest   = fair ? 1'b0 : ($urandom_range(0, 3) == 0);
      pres            = (beatq.size() > 0) && (fair || $urandom_range(0, 2) != 0);
      m_readdatavalid = pres;
      m_readdata      = pres ? beatq[0].data : {32'($urandom), 32'($urandom)};
      drive_clients();
      @(negedge clk);
      chk("one_grant", 64'($countones(~c_waitrequest) <= 1), 64'd1);
      for (int i = 0; i < NCH; i++)
        if (cl_act[i] && cl_wr[i] && cl_beat[i] > 0)
          for (int j = 0; j < NCH; j++)
            if (j != i) chk("burst_lock", 64'(c_waitrequest[j]), 64'd1);
      if (pres) begin
        chk("rdv_route", 64'(c_readdatavalid), 64'(3'b001 << beatq[0].ch));
        chk("rdata", c_readdata, beatq[0].data);
        void'(beatq.pop_front());
      end else begin
        chk("rdv_idle", 64'(c_readdatavalid), 64'd0);
      end
      if (m_read && !m_waitrequest) begin
        ch = int'(m_address[21:20]);
        for (int k = 0; k < int'(m_burstcount); k++)
          beatq.push_back('{data: {3'b000, m_address, 32'(k)}, ch: ch});
      end
      for (int i = 0; i < NCH; i++) begin
        if (cl_act[i] && cl_rd[i] && !c_waitrequest[i]) begin
          chk("rd_strobe", 64'(m_read), 64'd1);
          chk("rd_addr", 64'(m_address), 64'(cl_addr[i]));
          chk("rd_burst", 64'(m_burstcount), 64'(cl_bc[i]));
          if (fair) chk("rr_order", 64'(i), 64'((last_ch + 1) % NCH));
          last_ch = i;
          grants[i]++;
          cl_act[i] = 1'b0; cl_rd[i] = 1'b0;
        end else if (cl_act[i] && cl_wr[i] && !c_waitrequest[i]) begin
          chk("wr_strobe", 64'(m_write), 64'd1);
          chk("wr_data", m_writedata, cl_wd[i]);
          chk("wr_be", 64'(m_byteenable), 64'(cl_be[i]));
          if (cl_beat[i] == 0) chk("wr_addr", 64'(m_address), 64'(cl_addr[i]));
          cl_beat[i]++;
          cl_left[i]--;
          cl_wd[i] = {8'(i), 24'(cl_beat[i]), 32'($urandom)};
          if (cl_left[i] == 0) begin cl_act[i] = 1'b0; cl_wr[i] = 1'b0; end
        end
      end
      cyc++;
      if (cyc >= ncyc) stop = 1'b1;
      idle = (beatq.size() == 0);
      for (int i = 0; i < NCH; i++) if (cl_act[i]) idle = 1'b0;
      if (stop && idle) break;
      if (cyc > ncyc + 2000) begin chk("drain_timeout", 64'd0, 64'd1); break; end
    end
    if (fair) begin
      for (int i = 0; i < NCH; i++)
        for (int j = 0; j < NCH; j++)
          chk("fair_share", 64'((grants[i] - grants[j]) <= 1), 64'd1);
    end
    chk("rand_no_err", 64'(err_rdv), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t4_exp [5];
    logic [2:0] exp_w;
    bit seen;
    int beats, stall;

    // Arbitration table from reset: {reads, writes, expected grant}.
    tbl[0] = '{3'b001, 3'b000, 2'd0};
    tbl[1] = '{3'b111, 3'b000, 2'd1};
    tbl[2] = '{3'b111, 3'b000, 2'd2};
    tbl[3] = '{3'b000, 3'b110, 2'd1};
    tbl[4] = '{3'b001, 3'b000, 2'd0};
    tbl[5] = '{3'b101, 3'b000, 2'd2};
    tbl[6] = '{3'b000, 3'b011, 2'd0};
    tbl[7] = '{3'b100, 3'b001, 2'd2};
    tbl[8] = '{3'b000, 3'b100, 2'd2};
    tbl[9] = '{3'b011, 3'b000, 2'd0};
    t4_exp = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001};

    // Reset values and a single read with a 0xDEAD response.
    do_reset();
    @(negedge clk);
    chk("rst_wait", 64'(c_waitrequest), 64'h7);
    chk("rst_mread", 64'(m_read), 64'd0);
    chk("rst_mwrite", 64'(m_write), 64'd0);
    chk("rst_rdv", 64'(c_readdatavalid), 64'd0);
    chk("rst_err", 64'(err_rdv), 64'd0);
    @(posedge clk); #1;
    cl_rd[0] = 1'b1; cl_addr[0] = AW'(29'h100); drive_clients();
    wait_accept(0, "t1_accept");
    chk("t1_addr", 64'(m_address), 64'h100);
    @(posedge clk); #1;
    cl_rd[0] = 1'b0; drive_clients();
    repeat (4) @(posedge clk);
    #1 m_readdatavalid = 1'b1; m_readdata = 64'hDEAD;
    @(negedge clk);
    chk("t1_rdv", 64'(c_readdatavalid), 64'h1);
    chk("t1_data", c_readdata, 64'hDEAD);
    @(posedge clk); #1 m_readdatavalid = 1'b0;

    // Table-driven round-robin arbitration.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) begin
        cl_rd[i] = tbl[r].rd[i]; cl_wr[i] = tbl[r].wr[i];
      end
      drive_clients();
      @(negedge clk);
      chk("tbl_idle_wait", 64'(c_waitrequest), 64'h7);
      @(negedge clk);
      exp_w = ~(3'b001 << tbl[r].g);
      chk("tbl_grant", 64'(c_waitrequest), 64'(exp_w));
      chk("tbl_mread", 64'(m_read), 64'(tbl[r].rd[tbl[r].g]));
      chk("tbl_mwrite", 64'(m_write), 64'(tbl[r].wr[tbl[r].g]));
      chk("tbl_addr", 64'(m_address), 64'(cl_addr[tbl[r].g]));
    end

    // Write burst of 4 on ch1 with a 3-cycle stall on beat 2; ch2 must wait.
    do_reset();
    @(posedge clk); #1;
    beats = 0; stall = 0; seen = 1'b0;
    cl_bc[1] = 8'd4; cl_rd[2] = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      m_waitrequest = (beats == 1) && (stall < 3);
      if (m_waitrequest) stall++;
      cl_wd[1] = 64'(beats); cl_wr[1] = (beats < 4);
      drive_clients();
      @(negedge clk);
      if (beats < 4) begin
        chk("t3_ch2_held", 64'(c_waitrequest[2]), 64'd1);
        if (m_waitrequest) chk("t3_stall", 64'(c_waitrequest[1]), 64'd1);
        if (!c_waitrequest[1]) begin
          chk("t3_wdata", m_writedata, 64'(beats));
          beats++;
        end
      end else if (!c_waitrequest[2]) seen = 1'b1;
    end
    chk("t3_beats", 64'(beats), 64'd4);
    chk("t3_ch2_granted", 64'(seen), 64'd1);

    // Two outstanding read bursts return in command order.
    do_reset();
    @(posedge clk); #1;
    cl_rd[2] = 1'b1; cl_bc[2] = 8'd2; drive_clients();
    wait_accept(2, "t4_acc2");
    @(posedge clk); #1;
    cl_rd[2] = 1'b0; cl_rd[0] = 1'b1; cl_bc[0] = 8'd3; drive_clients();
    wait_accept(0, "t4_acc0");
    @(posedge clk); #1;
    cl_rd[0] = 1'b0; drive_clients();
    for (int k = 0; k < 5; k++) begin
      m_readdatavalid = 1'b1; m_readdata = 64'(k + 10);
      @(negedge clk);
      chk("t4_route", 64'(c_readdatavalid), 64'(t4_exp[k]));
      chk("t4_data", c_readdata, 64'(k + 10));
      @(posedge clk); #1;
    end
    m_readdatavalid = 1'b0;

    // Tag FIFO full: 9th read stalls while another client's write proceeds.
    do_reset();
    @(posedge clk); #1;
    cl_rd[0] = 1'b1; drive_clients();
    for (int k = 0; k < 8; k++) begin
      wait_accept(0, "t5_fill");
      @(posedge clk); #1;
    end
    cl_wr[1] = 1'b1; drive_clients();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t5_read_held", 64'(c_waitrequest[0]), 64'd1);
      if (!c_waitrequest[1]) seen = 1'b1;
      @(posedge clk); #1;
      if (seen) begin cl_wr[1] = 1'b0; drive_clients(); end
    end
    chk("t5_write_granted", 64'(seen), 64'd1);
    m_readdatavalid = 1'b1;
    @(negedge clk);
    chk("t5_pop_rdv", 64'(c_readdatavalid), 64'h1);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    wait_accept(0, "t5_after_pop");

    // Burstcount 0 acts as 1; an extra beat is orphaned and sets err_rdv.
    do_reset();
    @(posedge clk); #1;
    cl_rd[1] = 1'b1; cl_bc[1] = 8'd0; drive_clients();
    wait_accept(1, "t6_acc_bc0");
    @(posedge clk); #1;
    cl_rd[1] = 1'b0; drive_clients();
    m_readdatavalid = 1'b1;
    @(negedge clk);
    chk("t6_bc0_rdv", 64'(c_readdatavalid), 64'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_orphan_rdv", 64'(c_readdatavalid), 64'd0);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t6_err_set", 64'(err_rdv), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_err_sticky", 64'(err_rdv), 64'd1);

    // Asynchronous reset in the middle of a write burst with a read pending.
    do_reset();
    @(posedge clk); #1;
    cl_rd[0] = 1'b1; cl_bc[0] = 8'd4; drive_clients();
    wait_accept(0, "t6_acc_rd");
    @(posedge clk); #1;
    cl_rd[0] = 1'b0; cl_wr[2] = 1'b1; cl_bc[2] = 8'd4; drive_clients();
    wait_accept(2, "t6_acc_wr");
    @(posedge clk); #1;
    m_readdatavalid = 1'b1;
    @(negedge clk);
    chk("t6_pre_mwrite", 64'(m_write), 64'd1);
    chk("t6_pre_rdv", 64'(c_readdatavalid), 64'h1);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("t6_async_mwrite", 64'(m_write), 64'd0);
    chk("t6_async_wait", 64'(c_waitrequest), 64'h7);
    chk("t6_async_rdv", 64'(c_readdatavalid), 64'd0);
    chk("t6_async_err", 64'(err_rdv), 64'd0);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0; cl_wr[2] = 1'b0; drive_clients();
    @(posedge clk); #1 reset_reset_n = 1'b1;
    @(posedge clk); #1 m_readdatavalid = 1'b1;
    @(negedge clk);
    chk("t6_stale_rdv", 64'(c_readdatavalid), 64'd0);
    @(posedge clk); #1 m_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t6_stale_err", 64'(err_rdv), 64'd1);

    // Equal-share round robin with all three clients reading every cycle.
    do_reset();
    run_random(150, 1'b1);

    // Mixed randomized traffic with port stalls and random response timing.
    do_reset();
    run_random(1500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
